// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b.sv
// ---------------------------------------------------------------------------
// ddr2_blk_rdwr_fifo_72b_2_64b
//
// Read-return width converter for the DDR2 block-read path. 72-bit words are
// re-packed into 64-bit words for the packet side. Every 8 input words
// (576 bits) produce exactly 9 output words. Byte order is big-endian, and no
// bytes are padded or lost.
//
// Datapath: input FIFO (72b) -> converter with residual register -> output
// FIFO (64b). Both FIFOs are fallthrough: the head entry is visible at the
// output without a pop.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   wr_data     72-bit input word; byte 0 is wr_data[71:64]
//   wr_en       push wr_data into the input FIFO
//   full        input FIFO nearly full (at most one free entry)
//   rd_en       pop one 64-bit word from the output FIFO
//   rd_data     output FIFO head (fallthrough, valid while !empty)
//   rd_data_d1  rd_data registered by one cycle
//   empty       output FIFO empty
//   aligned     residual byte count is zero (on a 576-bit boundary)
// ---------------------------------------------------------------------------

// Small fallthrough FIFO. A push is ignored when the FIFO is completely full,
// and a pop is ignored when it is empty.
module ddr2_rdwr_small_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             nearly_full
);
    localparam int                    DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   NF_CNT    = DEPTH_CNT - (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE   = DEPTH_BITS'(1);
    localparam logic [DEPTH_BITS:0]   CNT_ONE   = (DEPTH_BITS + 1)'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block can leave it unassigned and infer a latch.
        do_push  = push && (count_q != DEPTH_CNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples values from before the clock edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset. Validity is tracked by the
    // pointers and count alone, which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head        = mem[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= NF_CNT);
endmodule

module ddr2_blk_rdwr_fifo_72b_2_64b #(
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [71:0] wr_data,
    input  logic        wr_en,
    output logic        full,
    input  logic        rd_en,
    output logic [63:0] rd_data,
    output logic [63:0] rd_data_d1,
    output logic        empty,
    output logic        aligned
);
    logic [71:0] in_head;
    logic        in_pop;
    logic        in_empty;
    logic        in_nf;

    logic [63:0] out_push_data;
    logic        out_push;
    logic        out_empty;
    logic        out_nf;
    logic        out_pop;

    // cnt_q counts the valid residual bytes (0..8). Those bytes are
    // left-justified in residual_q, and all unused low bits are kept at zero.
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] residual_q, residual_d;
    logic [63:0] rd_data_d1_q, rd_data_d1_d;

    logic [6:0]  hi_shift;
    logic [6:0]  lo_shift;
    logic [63:0] in_hi_bits;
    logic [63:0] in_lo_bits;

    ddr2_rdwr_small_fifo #(
        .WIDTH      (72),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (wr_en),
        .push_data   (wr_data),
        .pop         (in_pop),
        .head        (in_head),
        .empty       (in_empty),
        .nearly_full (in_nf)
    );

    ddr2_rdwr_small_fifo #(
        .WIDTH      (64),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (out_push),
        .push_data   (out_push_data),
        .pop         (out_pop),
        .head        (rd_data),
        .empty       (out_empty),
        .nearly_full (out_nf)
    );

    // Converter step. The input word's leading (8 - cnt) bytes fill the word
    // below the residual bytes. Its trailing (cnt + 1) bytes become the new
    // residual, shifted up to bit 63. The shift amounts below apply only when
    // cnt < 8, so cnt[2:0] is enough.
    always_comb begin
        hi_shift      = 7'd8 + {1'b0, cnt_q[2:0], 3'b000};
        lo_shift      = 7'd56 - {1'b0, cnt_q[2:0], 3'b000};
        in_hi_bits    = 64'(in_head >> hi_shift);
        in_lo_bits    = 64'(in_head << lo_shift);

        cnt_d         = cnt_q;
        residual_d    = residual_q;
        in_pop        = 1'b0;
        out_push      = 1'b0;
        out_push_data = residual_q;

        if (cnt_q == 4'd8) begin
            // A full residual word drains without consuming input.
            if (!out_nf) begin
                out_push   = 1'b1;
                cnt_d      = 4'd0;
                residual_d = '0;
            end
        end else if (!in_empty && !out_nf) begin
            in_pop        = 1'b1;
            out_push      = 1'b1;
            out_push_data = residual_q | in_hi_bits;
            residual_d    = in_lo_bits;
            cnt_d         = cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_data_d1_d = rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            residual_q   <= '0;
            rd_data_d1_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            residual_q   <= residual_d;
            rd_data_d1_q <= rd_data_d1_d;
        end
    end

    assign out_pop    = rd_en && !out_empty;
    assign full       = in_nf;
    assign empty      = out_empty;
    assign aligned    = (cnt_q == 4'd0);
    assign rd_data_d1 = rd_data_d1_q;
endmodule
